// File: rtl/fp_mul_iter.sv
// Sequential IEEE-754 multiplier: radix-2 shift-add significand product, bit-serial
// normalisation, round-to-nearest-even, subnormal support, valid/ready handshakes.
module fp_mul_iter #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [4:0]             flags
);

    localparam int unsigned W       = 1 + EXP_W + MAN_W;
    localparam int unsigned MW      = MAN_W + 1;
    localparam int unsigned PW      = 2 * MW;
    localparam int unsigned EW2     = EXP_W + 2;
    localparam int unsigned TOP     = PW - 1;
    localparam int unsigned LEAD    = 2 * MAN_W;
    localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;
    localparam int unsigned CNT_W   = $clog2(MW + 1);

    localparam logic signed [EW2-1:0] ONE_S   = EW2'(1);
    localparam logic signed [EW2-1:0] EMAX_S  = EW2'(EXP_MAX);
    localparam logic [W-1:0]          QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_NORM, S_ROUND, S_DONE} state_t;

    state_t                 state_q;
    logic                   pend_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [W-1:0]           result_q;
    logic [4:0]             flags_q;
    logic [W-1:0]           a_q;
    logic [W-1:0]           b_q;
    logic                   sign_q;
    logic signed [EW2-1:0]  exp_q;
    logic [PW-1:0]          prod_q;
    logic [PW-1:0]          mcand_q;
    logic [MW-1:0]          mplier_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sticky_q;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    // Operand field decode of the latched operands
    logic                  sa, sb;
    logic [EXP_W-1:0]      ea, eb, ea_eff, eb_eff;
    logic [MAN_W-1:0]      fa, fb;
    logic                  a_ez, b_ez, a_eo, b_eo;
    logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [MW-1:0]         sig_a, sig_b;
    logic signed [EW2-1:0] exp_sum;

    assign {sa, ea, fa} = a_q;
    assign {sb, eb, fb} = b_q;
    assign a_ez   = (ea == '0);
    assign b_ez   = (eb == '0);
    assign a_eo   = (ea == '1);
    assign b_eo   = (eb == '1);
    assign a_zero = a_ez && (fa == '0);
    assign b_zero = b_ez && (fb == '0);
    assign a_inf  = a_eo && (fa == '0);
    assign b_inf  = b_eo && (fb == '0);
    assign a_nan  = a_eo && (fa != '0);
    assign b_nan  = b_eo && (fb != '0);
    assign sig_a  = {~a_ez, fa};
    assign sig_b  = {~b_ez, fb};
    assign ea_eff = a_ez ? EXP_W'(1) : ea;
    assign eb_eff = b_ez ? EXP_W'(1) : eb;
    assign exp_sum = EW2'(ea_eff) + EW2'(eb_eff) - EW2'(BIAS);

    // Special-operand results, highest priority first
    logic          spec_hit;
    logic [W-1:0]  spec_res;
    logic [4:0]    spec_flags;

    always_comb begin
        spec_hit   = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_res   = QNAN;
            spec_flags = 5'b10000;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_res   = QNAN;
            spec_flags = 5'b10000;
        end else if (a_inf || b_inf) begin
            spec_res = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            spec_res = {sa ^ sb, {(W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Round-to-nearest-even on the normalised product
    logic                  guard, rs, inexact, rnd_up, tiny, ovf;
    logic [MW:0]           sig_r;
    logic signed [EW2-1:0] exp_r;
    logic [MAN_W-1:0]      frac_r;
    logic [W-1:0]          rnd_res;
    logic [4:0]            rnd_flags;

    always_comb begin
        guard   = prod_q[MAN_W-1];
        rs      = (|prod_q[MAN_W-2:0]) | sticky_q;
        inexact = guard | rs;
        rnd_up  = guard & (rs | prod_q[MAN_W]);
        tiny    = ~prod_q[LEAD];
        sig_r   = {1'b0, prod_q[LEAD:MAN_W]} + (MW+1)'(rnd_up);
        exp_r   = '0;
        frac_r  = sig_r[MAN_W-1:0];
        if (sig_r[MW]) begin
            exp_r  = exp_q + ONE_S;
            frac_r = '0;
        end else if (sig_r[MAN_W]) begin
            exp_r = exp_q;
        end
        ovf = (exp_r >= EMAX_S);
        if (ovf) begin
            rnd_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            rnd_res = {sign_q, exp_r[EXP_W-1:0], frac_r};
        end
        rnd_flags = {1'b0, 1'b0, ovf, tiny & inexact & ~ovf, inexact | ovf};
    end

    logic signed [EW2-1:0] exp_inc, exp_dec;
    assign exp_inc = exp_q + ONE_S;
    assign exp_dec = exp_q - ONE_S;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pend_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            prod_q      <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pend_q) begin
                        // Operands were latched last cycle; classify and launch
                        pend_q <= 1'b0;
                        sign_q <= sa ^ sb;
                        if (spec_hit) begin
                            result_q    <= spec_res;
                            flags_q     <= spec_flags;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            prod_q   <= '0;
                            mcand_q  <= {{MW{1'b0}}, sig_a};
                            mplier_q <= sig_b;
                            cnt_q    <= '0;
                            exp_q    <= exp_sum;
                            sticky_q <= 1'b0;
                            state_q  <= S_MUL;
                        end
                    end else if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        pend_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (mplier_q[0]) begin
                        prod_q <= prod_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MAN_W)) begin
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    // Right shifts collect sticky; left shifts stop at exponent 1
                    if (prod_q[TOP] || (exp_q < ONE_S)) begin
                        prod_q   <= prod_q >> 1;
                        sticky_q <= sticky_q | prod_q[0];
                        exp_q    <= exp_inc;
                        if (exp_inc >= ONE_S) begin
                            state_q <= S_ROUND;
                        end
                    end else if (!prod_q[LEAD] && (exp_q > ONE_S)) begin
                        prod_q <= prod_q << 1;
                        exp_q  <= exp_dec;
                        if (prod_q[LEAD-1] || (exp_dec == ONE_S)) begin
                            state_q <= S_ROUND;
                        end
                    end else begin
                        state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    result_q    <= rnd_res;
                    flags_q     <= rnd_flags;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_iter.sv
// Directed, table-driven bench for fp_mul_iter (binary32 build plus a binary16 build).
module tb_fp_mul_iter;

    localparam int TMO = 400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [4:0]  flags;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_result;
    logic [4:0]  h_flags;

    always #5 clk = ~clk;

    fp_mul_iter #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_mul_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .flags(h_flags)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;   // 0: latency not checked
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, got, want);
        end
    endtask

    // Drive one operation, count cycles from accept edge to out_valid, then take the result
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v,
                         output logic [31:0] r, output logic [4:0] f, output int lat, output logic vld);
        int n;
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < TMO) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        vld = out_valid;
        r   = result;
        f   = flags;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        logic        vld;

        vecs[0]  = '{32'h40400000, 32'h40000000, 32'h40C00000, 5'h00, 27};
        vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 5'h01, 27};
        vecs[2]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 5'h05, 27};
        vecs[3]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 5'h10, 1};
        vecs[4]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'h00, 1};
        vecs[5]  = '{32'h00800000, 32'h3F000000, 32'h00400000, 5'h00, 27};
        vecs[6]  = '{32'h00000001, 32'h3F000000, 32'h00000000, 5'h03, 27};
        vecs[7]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 5'h00, 27};
        vecs[8]  = '{32'hBFC00000, 32'h40000000, 32'hC0400000, 5'h00, 27};
        vecs[9]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 5'h01, 27};
        vecs[10] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 5'h01, 27};
        vecs[11] = '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 5'h01, 27};
        vecs[12] = '{32'h00FFFFFF, 32'h3F000000, 32'h00800000, 5'h03, 27};
        vecs[13] = '{32'h00400000, 32'h40000000, 32'h00800000, 5'h00, 0};
        vecs[14] = '{32'h00000001, 32'h00000001, 32'h00000000, 5'h03, 0};
        vecs[15] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'h10, 1};
        vecs[16] = '{32'hFFC00000, 32'h7F800000, 32'h7FC00000, 5'h10, 1};
        vecs[17] = '{32'h00000000, 32'hBF800000, 32'h80000000, 5'h00, 1};
        vecs[18] = '{32'h7F800000, 32'hFF800000, 32'hFF800000, 5'h00, 1};
        vecs[19] = '{32'h80000000, 32'hFF800000, 32'h7FC00000, 5'h10, 1};
        vecs[20] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'h00, 27};
        vecs[21] = '{32'h7F800000, 32'h00000001, 32'h7F800000, 5'h00, 1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        h_in_valid = 1'b0;
        h_out_ready = 1'b0;
        h_a = '0;
        h_b = '0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("rst_in_ready", 0, 32'(in_ready), 32'd1);
        chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
        chk("rst_result", 0, result, 32'd0);
        chk("rst_flags", 0, 32'(flags), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].a, vecs[i].b, r, f, lat, vld);
            chk("out_valid", i, 32'(vld), 32'd1);
            chk("result", i, r, vecs[i].res);
            chk("flags", i, 32'(f), 32'(vecs[i].flg));
            if (vecs[i].lat != 0) begin
                chk("latency", i, 32'(lat), 32'(vecs[i].lat));
            end
        end

        // Result held while out_ready is low; operands offered while busy are ignored
        a = 32'h40400000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("busy_in_ready", 0, 32'(in_ready), 32'd0);
        a = 32'h3F800000;
        b = 32'h3F800000;
        lat = 0;
        while (!out_valid && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hold_out_valid", 0, 32'(out_valid), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            chk("hold_result", k, result, 32'h40C00000);
            chk("hold_flags", k, 32'(flags), 32'd0);
            chk("hold_in_ready", k, 32'(in_ready), 32'd0);
            chk("hold_out_valid", k, 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", 0, 32'(out_valid), 32'd0);
        chk("release_in_ready", 0, 32'(in_ready), 32'd1);

        // Reset in the middle of the multiply discards the operation
        a = 32'h40400000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_ready", 0, 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 0, 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(32'h3FC00000, 32'h40000000, r, f, lat, vld);
        chk("post_rst_valid", 0, 32'(vld), 32'd1);
        chk("post_rst_result", 0, r, 32'h40400000);
        chk("post_rst_flags", 0, 32'(f), 32'd0);

        // binary16 build: 3.0 * 2.0
        h_a = 16'h4200;
        h_b = 16'h4000;
        h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        lat = 0;
        while (!h_out_valid && lat < TMO) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("h_out_valid", 0, 32'(h_out_valid), 32'd1);
        chk("h_result", 0, 32'(h_result), 32'h00004600);
        chk("h_flags", 0, 32'(h_flags), 32'd0);
        chk("h_latency", 0, 32'(lat), 32'd14);
        h_out_ready = 1'b1;
        @(posedge clk); #1;
        h_out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
